nibble_serial_addsub: RTL



---
 rtl/nibble_serial_addsub_if.sv | 19 +
 rtl/nibble_serial_addsub.sv | 105 ++++++++++
 2 files changed

// File: rtl/nibble_serial_addsub_if.sv
// Request/response bundle for the nibble-serial add/subtract unit.
// The master drives the operation request; the slave (the unit) returns status, result and flags.
interface nibble_serial_addsub_if;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;

  modport master (output start, op, a, b,
                  input  busy, done, result, flag_z, flag_v, flag_n);
  modport slave  (input  start, op, a, b,
                  output busy, done, result, flag_z, flag_v, flag_n);
endinterface

// File: rtl/nibble_serial_addsub.sv
// 16-bit ADD/SUB/PADDSB computed one nibble per clock through a single 4-bit CLA slice.
// Whole-word saturation for ADD/SUB, per-nibble saturation for PADDSB.
module nibble_serial_addsub (
  input  logic                          clk,
  input  logic                          rst_n,
  nibble_serial_addsub_if.slave         bus
);
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_PADD = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  nib_q, op_q;
  logic [15:0] a_q, b_q, wrk_q, res_q;
  logic        cy_q, z_q, v_q, n_q;

  logic        accept;
  logic [3:0]  base, a_n, b_n, g, p, sum, nib_out;
  logic [4:0]  c;
  logic        cin, ovf;
  logic [15:0] wrk_nx, final_w;

  assign accept = bus.start && (bus.op != OP_RSV) && (state_q != S_RUN);

  // Carry-lookahead slice on the current nibble
  assign base = {nib_q, 2'b00};
  assign a_n  = a_q[base +: 4];
  assign b_n  = b_q[base +: 4];
  assign g    = a_n & b_n;
  assign p    = a_n ^ b_n;
  assign cin  = (op_q == OP_PADD) ? 1'b0 :
                (nib_q == 2'd0)   ? (op_q == OP_SUB) : cy_q;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign sum  = p ^ c[3:0];
  assign ovf  = c[4] ^ c[3];

  assign nib_out = ((op_q == OP_PADD) && ovf) ? (a_n[3] ? 4'b1000 : 4'b0111) : sum;

  always_comb begin
    wrk_nx = wrk_q;
    wrk_nx[base +: 4] = nib_out;
  end

  // ovf here is only meaningful as the final word overflow when nib_q == 3
  assign final_w = ((op_q != OP_PADD) && ovf) ? (a_q[15] ? 16'h8000 : 16'h7FFF) : wrk_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (nib_q == 2'd3) state_d = S_DONE;
      S_DONE:  state_d = accept ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == S_RUN);
    bus.done = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0; b_q <= '0; op_q <= OP_ADD; nib_q <= '0; cy_q <= 1'b0;
      wrk_q <= '0; res_q <= '0; z_q <= 1'b0; v_q <= 1'b0; n_q <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.a;
      b_q   <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
      op_q  <= bus.op;
      nib_q <= '0;
      cy_q  <= 1'b0;
    end else if (state_q == S_RUN) begin
      wrk_q <= wrk_nx;
      cy_q  <= c[4];
      nib_q <= nib_q + 2'd1;
      if (nib_q == 2'd3) begin
        res_q <= final_w;
        if (op_q != OP_PADD) begin
          z_q <= (final_w == 16'h0000);
          v_q <= ovf;
          n_q <= final_w[15];
        end
      end
    end
  end

  assign bus.result = res_q;
  assign bus.flag_z = z_q;
  assign bus.flag_v = v_q;
  assign bus.flag_n = n_q;
endmodule
